// File: rtl/sccb_init_sequencer_if.sv
// Command bus between the init sequencer and the 2-wire SCCB master.
// Ports: sccb_start/rw/ip_addr/reg_addr/data_in (sequencer -> master),
//        sccb_done (master -> sequencer, level).
interface sccb_init_sequencer_if;
    logic       sccb_start;
    logic       sccb_rw;
    logic [7:0] sccb_ip_addr;
    logic [7:0] sccb_reg_addr;
    logic [7:0] sccb_data_in;
    logic       sccb_done;

    // master: the side issuing commands (the init sequencer)
    modport master (
        output sccb_start, sccb_rw, sccb_ip_addr, sccb_reg_addr, sccb_data_in,
        input  sccb_done
    );

    // slave: the SCCB bus engine executing the commands
    modport slave (
        input  sccb_start, sccb_rw, sccb_ip_addr, sccb_reg_addr, sccb_data_in,
        output sccb_done
    );
endinterface

// File: rtl/sccb_init_sequencer.sv
// Walks a 64-entry camera init ROM, issuing one SCCB write per entry, with ms delays.
// Latency: FETCH->START->start high is 2 cycles; GAP_CYCLES idle after done falls.
// Backpressure: holds start and reg/data stable until sccb_done or timeout; never starts on a stale done.
// Ports: XCLK/RST_N clock and async active-low reset; init_go start pulse;
//        sccb command bus (master modport); busy/init_done/init_err status; rom_index.
module sccb_init_sequencer #(
    parameter logic [7:0]  DEV_ID         = 8'h42,
    parameter int unsigned MS_CYCLES      = 50000,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned GAP_CYCLES     = 1000
) (
    input  logic                         XCLK,
    input  logic                         RST_N,
    input  logic                         init_go,
    sccb_init_sequencer_if.master        sccb,
    output logic                         busy,
    output logic                         init_done,
    output logic                         init_err,
    output logic [5:0]                   rom_index
);

    localparam logic [23:0] TO_LAST  = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_START, S_WAIT, S_RELEASE,
        S_DELAY, S_NEXT, S_DONE, S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [7:0]  reg_q, reg_d;
    logic [7:0]  dat_q, dat_d;
    logic        start_q, start_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [23:0] dly_q, dly_d;
    logic [15:0] gap_q, gap_d;
    logic [23:0] to_q, to_d;

    logic [15:0] rom_w;
    logic [39:0] dly_prod;
    logic [23:0] dly_load;

    // {reg_addr, data}; FFFF ends the table, F0xx is an xx-millisecond pause.
    function automatic logic [15:0] rom_word(input logic [5:0] idx);
        case (idx)
            6'd0:    rom_word = 16'h1280;  // COM7 soft reset
            6'd1:    rom_word = 16'hF00A;  // let the sensor settle 10 ms
            6'd2:    rom_word = 16'h1204;
            6'd3:    rom_word = 16'h1100;
            6'd4:    rom_word = 16'h0C00;
            6'd5:    rom_word = 16'h3E00;
            6'd6:    rom_word = 16'h4010;
            default: rom_word = 16'hFFFF;
        endcase
    endfunction

    assign rom_w    = rom_word(idx_q);
    assign dly_prod = 40'(rom_w[7:0]) * 40'(MS_CYCLES);
    // Clamp oversized delays rather than letting the 24-bit counter wrap.
    assign dly_load = (|dly_prod[39:24]) ? 24'hFF_FFFF : dly_prod[23:0];

    always_ff @(posedge XCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            reg_q   <= '0;
            dat_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            dly_q   <= '0;
            gap_q   <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            reg_q   <= reg_d;
            dat_q   <= dat_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            dly_q   <= dly_d;
            gap_q   <= gap_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        reg_d   = reg_q;
        dat_d   = dat_q;
        start_d = start_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        dly_d   = dly_q;
        gap_d   = gap_q;
        to_d    = to_q;
        case (state_q)
            S_IDLE: begin
                if (init_go) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (rom_w == 16'hFFFF) begin
                    state_d = S_DONE;
                end else if (rom_w[15:8] == 8'hF0) begin
                    dly_d   = dly_load;
                    state_d = S_DELAY;
                end else begin
                    reg_d   = rom_w[15:8];
                    dat_d   = rom_w[7:0];
                    state_d = S_START;
                end
            end
            S_START: begin
                to_d = '0;
                // A done still high from the previous command must not look
                // like an instant completion of this one.
                if (!sccb.sccb_done) begin
                    start_d = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sccb.sccb_done) begin
                    start_d = 1'b0;
                    gap_d   = '0;
                    state_d = S_RELEASE;
                end else if (to_q >= TO_LAST) begin
                    start_d = 1'b0;
                    state_d = S_ERROR;
                end else begin
                    to_d = to_q + 24'd1;
                end
            end
            S_RELEASE: begin
                // Gap restarts if done is seen high again before it expires.
                if (sccb.sccb_done) begin
                    gap_d = '0;
                end else if (gap_q >= GAP_LAST) begin
                    state_d = S_NEXT;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            S_DELAY: begin
                if (dly_q == '0) state_d = S_NEXT;
                else             dly_d   = dly_q - 24'd1;
            end
            S_NEXT: begin
                if (idx_q == 6'd63) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 6'd1;
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_ERROR: begin
                err_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign sccb.sccb_start    = start_q;
    assign sccb.sccb_rw       = 1'b0;
    assign sccb.sccb_ip_addr  = DEV_ID;
    assign sccb.sccb_reg_addr = reg_q;
    assign sccb.sccb_data_in  = dat_q;
    assign busy               = busy_q;
    assign init_done          = done_q;
    assign init_err           = err_q;
    assign rom_index          = idx_q;

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Randomized bench for sccb_init_sequencer against a table-walking reference model.
// Latency: n/a (bench).
// Backpressure: model SCCB master raises done after a (random) latency and holds it.
module tb_sccb_init_sequencer;

    localparam int MS   = 10;
    localparam int TO   = 1500;
    localparam int GAP  = 40;

    logic       XCLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       init_go = 1'b0;
    logic       busy, init_done, init_err;
    logic [5:0] rom_index;

    sccb_init_sequencer_if bus();

    sccb_init_sequencer #(
        .DEV_ID(8'h42), .MS_CYCLES(MS), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)
    ) dut (
        .XCLK(XCLK), .RST_N(RST_N), .init_go(init_go), .sccb(bus),
        .busy(busy), .init_done(init_done), .init_err(init_err), .rom_index(rom_index)
    );

    always #5 XCLK = ~XCLK;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference model: walk the camera table as a list of writes and pauses.
    logic [15:0] rom_m [64];
    logic [15:0] exp_wr [$];
    int          dly_before [$];
    int          exp_n = 0;
    int          end_idx = 63;

    task automatic build_model();
        int acc;
        bit found;
        for (int i = 0; i < 64; i++) rom_m[i] = 16'hFFFF;
        rom_m[0] = 16'h1280; rom_m[1] = 16'hF00A; rom_m[2] = 16'h1204;
        rom_m[3] = 16'h1100; rom_m[4] = 16'h0C00; rom_m[5] = 16'h3E00;
        rom_m[6] = 16'h4010;
        acc = 0; found = 0;
        exp_wr.delete(); dly_before.delete();
        for (int i = 0; i < 64 && !found; i++) begin
            logic [15:0] w;
            w = rom_m[i];
            if (w == 16'hFFFF) begin
                end_idx = i; found = 1;
            end else if (w[15:8] == 8'hF0) begin
                acc += int'(w[7:0]);
            end else begin
                exp_wr.push_back(w);
                dly_before.push_back(acc);
                acc = 0;
            end
        end
        if (!found) end_idx = 63;
        exp_n = exp_wr.size();
    endtask

    // Model SCCB master.
    bit m_on = 1'b1;
    bit m_rand = 1'b0;
    int m_lat = 200;
    int m_hold = 500;

    initial begin
        int lat, hold;
        bus.sccb_done = 1'b0;
        forever begin
            @(posedge XCLK); #1;
            if (m_on && bus.sccb_start && !bus.sccb_done) begin
                lat  = m_rand ? int'($urandom_range(1, 400)) : m_lat;
                hold = m_rand ? int'($urandom_range(1, 600)) : m_hold;
                for (int i = 1; i < lat && bus.sccb_start; i++) begin
                    @(posedge XCLK); #1;
                end
                if (bus.sccb_start) begin
                    bus.sccb_done = 1'b1;
                    for (int i = 0; i < hold; i++) begin
                        @(posedge XCLK); #1;
                    end
                    bus.sccb_done = 1'b0;
                end
            end
        end
    end

    // Bus monitor, sampling on the falling edge.
    logic [7:0] cap_reg [$];
    logic [7:0] cap_dat [$];
    int  cyc = 0;
    int  last_fall = -1;
    int  rise_cyc = 0;
    int  fall_cyc = 0;
    int  bus_err = 0;
    logic prev_start = 1'b0, prev_done = 1'b0;
    logic [7:0] prev_reg = '0, prev_dat = '0;

    initial begin
        int k, diff, req;
        forever begin
            @(negedge XCLK);
            cyc++;
            if (bus.sccb_ip_addr !== 8'h42 || bus.sccb_rw !== 1'b0) bus_err++;
            if (bus.sccb_start && prev_start &&
                (bus.sccb_reg_addr !== prev_reg || bus.sccb_data_in !== prev_dat)) bus_err++;
            if (bus.sccb_start && !prev_start) begin
                k = cap_reg.size();
                cap_reg.push_back(bus.sccb_reg_addr);
                cap_dat.push_back(bus.sccb_data_in);
                rise_cyc = cyc;
                chk("start_while_done", {31'd0, bus.sccb_done}, 32'd0);
                if (k > 0 && k < exp_n && last_fall >= 0) begin
                    diff = cyc - last_fall;
                    req  = GAP + dly_before[k] * MS;
                    chk($sformatf("spacing_w%0d_got%0d_min%0d", k, diff, req),
                        {31'd0, diff >= req}, 32'd1);
                end
            end
            if (!bus.sccb_start && prev_start) fall_cyc = cyc;
            if (!bus.sccb_done && prev_done) last_fall = cyc;
            prev_start = bus.sccb_start;
            prev_done  = bus.sccb_done;
            prev_reg   = bus.sccb_reg_addr;
            prev_dat   = bus.sccb_data_in;
        end
    end

    task automatic pulse_go();
        @(negedge XCLK); init_go = 1'b1;
        @(negedge XCLK); init_go = 1'b0;
    endtask

    // Wait for busy to fall; pk=1 pokes init_go once during WAIT_DONE,
    // pk=2 pokes it at random while busy.
    task automatic wait_idle(input int budget, input int pk, output bit ok);
        bit poked;
        ok = 0; poked = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge XCLK);
            init_go = 1'b0;
            if (!busy) begin ok = 1; break; end
            if (pk == 1 && bus.sccb_start && !poked) begin
                init_go = 1'b1; poked = 1;
            end else if (pk == 2 && $urandom_range(0, 99) == 0) begin
                init_go = 1'b1;
            end
        end
        init_go = 1'b0;
    endtask

    task automatic clear_caps();
        cap_reg.delete(); cap_dat.delete();
        last_fall = -1; bus_err = 0;
    endtask

    task automatic run_seq(input string nm, input int lat, input int hold,
                           input bit rnd, input int pk);
        bit ok;
        clear_caps();
        m_on = 1; m_rand = rnd; m_lat = lat; m_hold = hold;
        pulse_go();
        wait_idle(30000, pk, ok);
        chk({nm, "_finished"}, {31'd0, ok}, 32'd1);
        chk({nm, "_start_count"}, cap_reg.size(), exp_n);
        for (int i = 0; i < exp_n; i++) begin
            logic [31:0] got;
            got = (i < cap_reg.size()) ? {16'd0, cap_reg[i], cap_dat[i]} : 32'hFFFF_FFFF;
            chk($sformatf("%s_pair%0d", nm, i), got, {16'd0, exp_wr[i]});
        end
        chk({nm, "_init_done"}, {31'd0, init_done}, 32'd1);
        chk({nm, "_init_err"}, {31'd0, init_err}, 32'd0);
        chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
        chk({nm, "_rom_index"}, {26'd0, rom_index}, end_idx);
        chk({nm, "_bus_stable"}, bus_err, 32'd0);
        repeat (5) @(negedge XCLK);
    endtask

    initial begin
        bit ok;
        build_model();

        // Reset state
        repeat (4) @(negedge XCLK);
        chk("rst_start", {31'd0, bus.sccb_start}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, init_done}, 32'd0);
        chk("rst_err", {31'd0, init_err}, 32'd0);
        chk("rst_index", {26'd0, rom_index}, 32'd0);
        chk("rst_ip_addr", {24'd0, bus.sccb_ip_addr}, 32'h42);
        chk("rst_reg_data", {16'd0, bus.sccb_reg_addr, bus.sccb_data_in}, 32'd0);
        RST_N = 1'b1;
        repeat (3) @(negedge XCLK);

        // Nominal sequence, with one stray init_go during WAIT_DONE
        run_seq("nominal", 200, 500, 1'b0, 1);

        // Randomized master timing and random init_go pokes
        for (int r = 0; r < 3; r++) run_seq($sformatf("rand%0d", r), 0, 0, 1'b1, 2);

        // Master never answers: timeout
        clear_caps();
        m_on = 0;
        pulse_go();
        wait_idle(5000, 0, ok);
        chk("to_finished", {31'd0, ok}, 32'd1);
        chk("to_start_count", cap_reg.size(), 32'd1);
        chk("to_start_high_cycles", fall_cyc - rise_cyc, TO);
        chk("to_init_err", {31'd0, init_err}, 32'd1);
        chk("to_init_done", {31'd0, init_done}, 32'd0);
        chk("to_rom_index", {26'd0, rom_index}, 32'd0);
        chk("to_start_low", {31'd0, bus.sccb_start}, 32'd0);
        repeat (5) @(negedge XCLK);

        // Reset during WAIT_DONE of entry 3
        clear_caps();
        m_on = 1; m_rand = 0; m_lat = 200; m_hold = 500;
        pulse_go();
        ok = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge XCLK);
            if (rom_index == 6'd3 && bus.sccb_start) begin ok = 1; break; end
        end
        chk("mid_reach_entry3", {31'd0, ok}, 32'd1);
        repeat (50) @(negedge XCLK);
        chk("mid_starts_before_rst", cap_reg.size(), 32'd3);
        #3 RST_N = 1'b0;
        #1;
        chk("mid_rst_start", {31'd0, bus.sccb_start}, 32'd0);
        chk("mid_rst_flags", {29'd0, busy, init_done, init_err}, 32'd0);
        chk("mid_rst_index", {26'd0, rom_index}, 32'd0);
        repeat (20) @(negedge XCLK);
        chk("mid_no_retry", {31'd0, bus.sccb_start}, 32'd0);
        RST_N = 1'b1;
        repeat (3) @(negedge XCLK);
        run_seq("after_rst", 200, 500, 1'b0, 0);

        // Long done: start must wait for done to fall, then the gap
        run_seq("long_done", 100, 2000, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
